// File: rtl/param_decode_stage.sv
// MIPS instruction-decode stage: register file with write-through bypass, branch target/compare,
// load-use hazard detection and the ID/EX pipeline register.
module param_decode_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ifidPcPlusFour,
    input  logic [31:0]       ifidInstruction,
    input  logic [CTRL_W-1:0] ctrlIn,
    input  logic              memReadIn,
    input  logic              regWriteIn,
    input  logic              flush,
    input  logic              wbWriteEnable,
    input  logic [4:0]        wbWriteReg,
    input  logic [DATA_W-1:0] wbWriteData,
    output logic [5:0]        opCode,
    output logic [DATA_W-1:0] branchAddress,
    output logic              branchEqual,
    output logic              stall,
    output logic              idexValid,
    output logic [DATA_W-1:0] idexReadData1,
    output logic [DATA_W-1:0] idexReadData2,
    output logic [4:0]        idexRs,
    output logic [4:0]        idexRt,
    output logic [4:0]        idexRd,
    output logic [DATA_W-1:0] idexImmediate,
    output logic [DATA_W-1:0] idexPcPlusFour,
    output logic [CTRL_W-1:0] idexCtrl,
    output logic              idexMemRead,
    output logic              idexRegWrite
);

    logic [4:0]        rs, rt, rd;
    logic signed [15:0] imm_s;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd1, rd2;
    logic              wb_active;
    logic              hazard;
    logic              bubble;

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              mem_read_q, mem_read_d;
    logic              reg_write_q, reg_write_d;

    always_comb begin
        opCode    = ifidInstruction[31:26];
        rs        = ifidInstruction[25:21];
        rt        = ifidInstruction[20:16];
        rd        = ifidInstruction[15:11];
        imm_s     = ifidInstruction[15:0];
        // Size cast of a signed operand replicates bit 15, and is legal even when DATA_W == 16.
        imm_ext   = DATA_W'(imm_s);
        wb_active = wbWriteEnable && (wbWriteReg != 5'd0);
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_active) begin
            regs_d[wbWriteReg] = wbWriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Write-through bypass so a value written at the coming edge is already visible in ID.
    always_comb begin
        if (wb_active && wbWriteReg == rs) begin
            rd1 = wbWriteData;
        end else if (rs == 5'd0) begin
            rd1 = '0;
        end else begin
            rd1 = regs_q[rs];
        end
        if (wb_active && wbWriteReg == rt) begin
            rd2 = wbWriteData;
        end else if (rt == 5'd0) begin
            rd2 = '0;
        end else begin
            rd2 = regs_q[rt];
        end
    end

    always_comb begin
        branchAddress = ifidPcPlusFour + (imm_ext << 2);
        branchEqual   = (rd1 == rd2);
        // rt is compared even for opcodes that do not read it; conservative by design.
        hazard = valid_q && mem_read_q && (rt_q != 5'd0) && ((rt_q == rs) || (rt_q == rt));
        stall  = hazard && !flush;
        bubble = flush || hazard;
    end

    always_comb begin
        valid_d     = 1'b0;
        rdata1_d    = '0;
        rdata2_d    = '0;
        rs_d        = '0;
        rt_d        = '0;
        rd_d        = '0;
        imm_d       = '0;
        pc4_d       = '0;
        ctrl_d      = '0;
        mem_read_d  = 1'b0;
        reg_write_d = 1'b0;
        if (!bubble) begin
            valid_d     = 1'b1;
            rdata1_d    = rd1;
            rdata2_d    = rd2;
            rs_d        = rs;
            rt_d        = rt;
            rd_d        = rd;
            imm_d       = imm_ext;
            pc4_d       = ifidPcPlusFour;
            ctrl_d      = ctrlIn;
            mem_read_d  = memReadIn;
            reg_write_d = regWriteIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            ctrl_q      <= '0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            pc4_q       <= pc4_d;
            ctrl_q      <= ctrl_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
        end
    end

    always_comb begin
        idexValid      = valid_q;
        idexReadData1  = rdata1_q;
        idexReadData2  = rdata2_q;
        idexRs         = rs_q;
        idexRt         = rt_q;
        idexRd         = rd_q;
        idexImmediate  = imm_q;
        idexPcPlusFour = pc4_q;
        idexCtrl       = ctrl_q;
        idexMemRead    = mem_read_q;
        idexRegWrite   = reg_write_q;
    end

endmodule
